// File: rtl/mult_err_acc.sv
// Error-metric accumulator for 8x8 approximate multipliers: compares R against the
// exact A*B and accumulates sum, max and count of error distances over a run.
module mult_err_acc #(
   parameter int CNT_W = 16,
   parameter int SUM_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       A,
   input  logic [7:0]       B,
   input  logic [15:0]      R,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] sum_ed,
   output logic [15:0]      max_ed,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] sample_cnt
);

   // state  | meaning
   // IDLE   | after reset, waiting for start
   // RUN    | accepting samples until the latched count is reached
   // DRAIN  | last sample accepted, pipeline emptying
   // DONE   | results final, waiting for a restart
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [SUM_W-1:0] SUM_MAX = '1;

   state_t           state_q, state_d;
   logic             clr_acc, lat_n, accept, last_accept;
   logic [CNT_W-1:0] n_lat, acc_cnt;

   logic             s1_v, s2_v, s2_err;
   logic [7:0]       s1_a, s1_b;
   logic [15:0]      s1_r, s2_ed;
   logic [15:0]      prod, ed;
   logic [SUM_W:0]   sum_wide;

   assign in_ready    = (state_q == ST_RUN);
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_DONE);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && (acc_cnt == n_lat - CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clr_acc = 1'b0;
      lat_n   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clr_acc = 1'b1;
               if (num_samples != '0) begin
                  lat_n   = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (last_accept) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // S1 empty means S2 holds the final sample, accumulated on this edge
            if (!s1_v) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat   <= '0;
         acc_cnt <= '0;
      end else if (lat_n) begin
         n_lat   <= num_samples;
         acc_cnt <= '0;
      end else if (accept) begin
         acc_cnt <= acc_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_r <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_a <= A;
            s1_b <= B;
            s1_r <= R;
         end
      end
   end

   always_comb begin
      prod = {8'd0, s1_a} * {8'd0, s1_b};
      ed   = (prod >= s1_r) ? (prod - s1_r) : (s1_r - prod);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v   <= 1'b0;
         s2_ed  <= '0;
         s2_err <= 1'b0;
      end else begin
         s2_v   <= s1_v;
         s2_ed  <= ed;
         s2_err <= (ed != 16'd0);
      end
   end

   // One extra bit catches the carry; a saturated sum keeps carrying for any ED>0
   assign sum_wide = {1'b0, sum_ed} + {{(SUM_W-15){1'b0}}, s2_ed};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ed     <= '0;
         max_ed     <= '0;
         err_cnt    <= '0;
         sample_cnt <= '0;
      end else if (clr_acc) begin
         sum_ed     <= '0;
         max_ed     <= '0;
         err_cnt    <= '0;
         sample_cnt <= '0;
      end else if (s2_v) begin
         sum_ed     <= sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
         if (s2_ed > max_ed) max_ed <= s2_ed;
         if (s2_err) err_cnt <= err_cnt + CNT_ONE;
         sample_cnt <= sample_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_mult_err_acc.sv
// Directed bench for mult_err_acc: table of runs with hand-computed results, plus
// reset, zero-length, restart and mid-run reset sequences. A SUM_W=16 copy checks saturation.
module tb_mult_err_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_samples = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  A = '0;
   logic [7:0]  B = '0;
   logic [15:0] R = '0;

   logic        in_ready, busy, done;
   logic [31:0] sum_ed;
   logic [15:0] max_ed, err_cnt, sample_cnt;

   logic        in_ready_s, busy_s, done_s;
   logic [15:0] sum_ed_s, max_ed_s, err_cnt_s, sample_cnt_s;

   mult_err_acc #(.CNT_W(16), .SUM_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .R(R),
      .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
      .err_cnt(err_cnt), .sample_cnt(sample_cnt)
   );

   mult_err_acc #(.CNT_W(16), .SUM_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready_s), .A(A), .B(B), .R(R),
      .busy(busy_s), .done(done_s), .sum_ed(sum_ed_s), .max_ed(max_ed_s),
      .err_cnt(err_cnt_s), .sample_cnt(sample_cnt_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] r;
   } samp_t;

   typedef struct {
      int          n;
      int          first;
      int          gap;
      int          glitch;
      int          lat;
      logic [63:0] exp_sum;
      logic [63:0] exp_sum16;
      logic [63:0] exp_max;
      logic [63:0] exp_err;
   } vec_t;

   samp_t samps[$];
   vec_t  vecs[$];
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic add_s(input int a, input int b, input int r);
      samp_t s;
      s.a = 8'(a);
      s.b = 8'(b);
      s.r = 16'(r);
      samps.push_back(s);
   endtask

   task automatic add_v(input int n, input int first, input int gap, input int glitch, input int lat,
                        input longint s32, input longint s16, input longint mx, input longint er);
      vec_t v;
      v.n = n; v.first = first; v.gap = gap; v.glitch = glitch; v.lat = lat;
      v.exp_sum = 64'(s32); v.exp_sum16 = 64'(s16); v.exp_max = 64'(mx); v.exp_err = 64'(er);
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int idx);
      vec_t  v;
      samp_t s;
      int    edges;
      string tag;
      v = vecs[idx];
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      start = 1'b1;
      num_samples = 16'(v.n);
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      chk({tag, " done_cleared"}, 64'(done), 64'd0);
      chk({tag, " busy_on_start"}, 64'(busy), 64'd1);
      chk({tag, " cnt_cleared"}, 64'(sample_cnt), 64'd0);
      chk({tag, " sum_cleared"}, 64'(sum_ed), 64'd0);
      for (int i = 0; i < v.n; i++) begin
         s = samps[v.first + i];
         in_valid = 1'b1;
         A = s.a; B = s.b; R = s.r;
         if (v.glitch == i) begin
            start = 1'b1;
            num_samples = 16'd1;
         end
         @(negedge clk);
         edges++;
         start = 1'b0;
         num_samples = 16'(v.n);
         in_valid = 1'b0;
         if (v.gap != 0 && i < v.n - 1) begin
            @(negedge clk);
            edges++;
         end
      end
      chk({tag, " in_ready_after_last"}, 64'(in_ready), 64'd0);
      while (!done && edges < 60) begin
         @(negedge clk);
         edges++;
      end
      chk({tag, " done_latency"}, 64'(edges), 64'(v.lat));
      chk({tag, " sum_ed"}, 64'(sum_ed), v.exp_sum);
      chk({tag, " sum_ed_w16"}, 64'(sum_ed_s), v.exp_sum16);
      chk({tag, " max_ed"}, 64'(max_ed), v.exp_max);
      chk({tag, " err_cnt"}, 64'(err_cnt), v.exp_err);
      chk({tag, " sample_cnt"}, 64'(sample_cnt), 64'(v.n));
      chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      add_s(255, 255, 65025); add_s(0, 77, 0); add_s(15, 15, 225);          // 0-2 exact
      add_s(15, 15, 200); add_s(16, 16, 300); add_s(2, 3, 6);               // 3-5 mix
      add_s(255, 255, 0); add_s(255, 255, 0); add_s(255, 255, 0);           // 6-8 sat
      add_s(1, 1, 0); add_s(0, 0, 65535);                                   // 9-10
      add_s(3, 3, 10); add_s(3, 3, 10); add_s(3, 3, 10); add_s(3, 3, 10);   // 11-14
      add_s(200, 100, 20001);                                               // 15
      add_s(2, 2, 5); add_s(2, 2, 5);                                       // 16-17

      add_v(3, 0, 0, -1, 5, 0, 0, 0, 0);
      add_v(3, 3, 1, -1, 7, 69, 69, 44, 2);
      add_v(3, 6, 0, -1, 5, 195075, 65535, 65025, 3);
      add_v(2, 9, 0, -1, 4, 65536, 65535, 65535, 2);
      add_v(4, 11, 0, 2, 6, 4, 4, 1, 4);
      add_v(1, 15, 0, -1, 3, 1, 1, 1, 1);
      add_v(2, 16, 0, -1, 4, 2, 2, 1, 2);

      // reset state, and no acceptance in IDLE
      repeat (2) @(negedge clk);
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst sum_ed", 64'(sum_ed), 64'd0);
      chk("rst max_ed", 64'(max_ed), 64'd0);
      chk("rst err_cnt", 64'(err_cnt), 64'd0);
      rst_n = 1'b1;
      in_valid = 1'b1;
      A = 8'd9; B = 8'd9; R = 16'd0;
      repeat (4) @(negedge clk);
      chk("idle sample_cnt", 64'(sample_cnt), 64'd0);
      chk("idle in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;

      for (int k = 0; k < 6; k++) run_vec(k);

      // zero-length run from DONE: clears previous results, done after one edge
      @(negedge clk);
      start = 1'b1;
      num_samples = 16'd0;
      @(negedge clk);
      start = 1'b0;
      chk("zero done", 64'(done), 64'd1);
      chk("zero busy", 64'(busy), 64'd0);
      chk("zero sum_ed", 64'(sum_ed), 64'd0);
      chk("zero max_ed", 64'(max_ed), 64'd0);
      chk("zero err_cnt", 64'(err_cnt), 64'd0);
      chk("zero sample_cnt", 64'(sample_cnt), 64'd0);

      // reset in the middle of a 10-sample run
      @(negedge clk);
      start = 1'b1;
      num_samples = 16'd10;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      A = 8'd10; B = 8'd10; R = 16'd0;
      repeat (4) @(negedge clk);
      chk("midrst pre sample_cnt", 64'(sample_cnt), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst sum_ed", 64'(sum_ed), 64'd0);
      chk("midrst max_ed", 64'(max_ed), 64'd0);
      chk("midrst err_cnt", 64'(err_cnt), 64'd0);
      chk("midrst sample_cnt", 64'(sample_cnt), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_err_acc.md
# mult_err_acc

Streaming error-metric accumulator that sits directly downstream of the 8x8 approximate multipliers in the Mult_8x8 library. It consumes operand pairs together with the approximate product, computes the exact product internally, and accumulates error statistics over a programmed number of samples:
- sum of error distance
- maximum error distance
- count of erroneous samples

It is used both in hardware characterisation runs and in the simulation benches that rank multiplier variants.

## Interface
Parameters:
- CNT_W, 16, width of sample counters and `num_samples`
- SUM_W, 32, width of the error-distance sum accumulator (must be ≥ 16)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a run (sampled only in IDLE or DONE)
- num_samples  input  CNT_W  samples per run; latched on accepted `start`
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample this cycle
- A  input  8  multiplicand fed to the multiplier under test
- B  input  8  multiplier operand fed to the multiplier under test
- R  input  16  approximate product from the multiplier under test
- busy  output  1  high in RUN or DRAIN
- done  output  1  level; high in DONE while results are final
- sum_ed  output  SUM_W  sum of |A*B − R|, saturating
- max_ed  output  16  maximum |A*B − R| seen this run
- err_cnt  output  CNT_W  number of samples with R ≠ A*B
- sample_cnt  output  CNT_W  samples accumulated this run

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- **IDLE:**
  - `in_ready`=0.
  - `start` with `num_samples`≠0: latch the count, clear all accumulators, go to RUN.
  - `start` with `num_samples`=0: clear accumulators, go to DONE.
- **RUN:**
  - `in_ready`=1 while accepted < latched count.
  - A sample is accepted on an edge where `in_valid`&`in_ready`.
  - On the edge accepting the last sample, go to DRAIN. `in_ready` drops in the next cycle.
- **DRAIN:**
  - `in_ready`=0.
  - Remain until the pipeline is empty, then go to DONE.
- **DONE:**
  - `done`=1; results hold.
  - `start` clears the accumulators and re-enters RUN (or stays in DONE if `num_samples`=0).
- **start elsewhere:** `start` in RUN or DRAIN is ignored.
- **Pipeline stage S1:** registers A, B, R and valid on acceptance.
- **Pipeline stage S2:**
  - Computes the exact product P = A*B (16-bit unsigned).
  - Computes ED = P ≥ R ? P−R : R−P (16-bit unsigned).
  - Computes the flag (ED≠0).
  - Registers ED, the flag and valid.
- **Pipeline stage S3 (accumulate), when S2 is valid:**
  - `sum_ed` += ED, saturating at 2^SUM_W−1. Once saturated it stays saturated until cleared.
  - `max_ed` = max(`max_ed`, ED).
  - `err_cnt` += flag.
  - `sample_cnt` += 1.
- **Arithmetic:** all arithmetic is unsigned. Operands are never sign-extended.
- **Flow control:** no backpressure beyond `in_ready`. The pipeline never stalls once a sample is accepted.

## Timing
- **Reset values (asynchronous):**
  - State IDLE.
  - `in_ready`, `busy`, `done` = 0.
  - `sum_ed`, `max_ed`, `err_cnt`, `sample_cnt` = 0.
  - Pipeline valids = 0.
- **Reset mid-run:** asserting reset during RUN or DRAIN aborts immediately to the reset values. Partial results are discarded.
- **Per-sample latency:** a sample accepted at edge t is registered in S1 at t, in S2 at t+1, and reflected in the accumulators after edge t+2.
- **Throughput:** one sample per cycle while `in_valid` is held high.
- **Run completion:**
  - Last sample accepted at edge t0.
  - DRAIN for cycles t0..t0+1.
  - DONE entered at edge t0+2, the same edge as the final accumulation. `done`=1 and final results become visible together.
  - For `num_samples`=N with continuous `in_valid`: `start` at edge s gives `done` high after edge s+N+2.
- **Zero-length run:** `start` with `num_samples`=0 gives `done` after the next edge, with all results 0.
- **Restart from DONE:** `start` in DONE drops `done` and clears the accumulators on the same edge.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Output validity:** `sum_ed`, `max_ed`, `err_cnt`, `sample_cnt` change only in RUN/DRAIN. They are guaranteed final only while `done`=1.
- **Gapped input:** `in_valid` gaps in RUN simply delay completion; no timeout.

## Test plan
- **Reset:** after reset, all outputs are 0 and `in_ready`=0. With `in_valid`=1 in IDLE, no sample is accepted and `sample_cnt` stays 0.
- **Exact run:**
  - Stimulus: N=3; samples (255,255,R=65025), (0,77,R=0), (15,15,R=225), `in_valid` continuous.
  - Required: `done` after edge s+5; `sum_ed`=0, `max_ed`=0, `err_cnt`=0, `sample_cnt`=3.
- **Error mix:**
  - Stimulus: N=3; (15,15,R=200), (16,16,R=300), (2,3,R=6), with one idle cycle between samples.
  - Required: `sum_ed`=69, `max_ed`=44, `err_cnt`=2, `sample_cnt`=3. `in_ready` is 0 from the cycle after the third acceptance.
- **Saturation (SUM_W=16 build):**
  - Stimulus: N=3; samples (255,255,R=0) ×3.
  - Required: `sum_ed`=65535 (saturated), `max_ed`=65025, `err_cnt`=3.
- **Control corners:**
  - `start` with `num_samples`=0 gives `done` after one edge, all results 0.
  - `start` pulsed during RUN is ignored and the run completes with the original N.
  - `start` in DONE clears results and a new run of N=1 completes correctly.
- **Reset mid-run:** with N=10, assert `rst_n`=0 after 4 accepted samples. All outputs return to 0 immediately, and a subsequent run of N=2 reports only its own 2 samples.
